// File: rtl/pilot_insert_pkg.sv
// pilot_insert_pkg: shared constants, FSM state type and pilot helper for the subcarrier mapper
package pilot_insert_pkg;
  localparam int N_CAR = 200;
  localparam logic [1:0] ALLOC_NULL = 2'b00;
  localparam logic [1:0] ALLOC_DATA = 2'b01;
  localparam int ALLOC_PILOT = 1;
  localparam logic [15:0] PILOT_AMP = 16'h2000;
  localparam logic [10:0] PRBS_INIT = 11'h7FF;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;
  function automatic logic [31:0] pilot_word(input logic wk, input logic [15:0] amp);
    return {16'h0, wk ? 16'h0 - amp : amp};
  endfunction
endpackage

// File: rtl/pilot_prbs.sv
// pilot_prbs: 11-bit pilot sign LFSR, reseeded per frame and stepped once per symbol
module pilot_prbs #(
  parameter logic [10:0] INIT = 11'h7FF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic step,
  output logic wk
);
  logic [10:0] prbs;
  always_ff @(posedge clk)
    if (!rst_n || load) prbs <= INIT;
    else if (step) prbs <= {prbs[9:0], prbs[10] ^ prbs[8]};
  assign wk = prbs[0];
endmodule

// File: rtl/pilot_insert.sv
// pilot_insert: maps a data symbol stream onto N_CAR carriers with PRBS-signed pilots and nulls
module pilot_insert #(
  parameter int          N_CAR     = pilot_insert_pkg::N_CAR,
  parameter logic [15:0] PILOT_AMP = pilot_insert_pkg::PILOT_AMP,
  parameter logic [10:0] PRBS_INIT = pilot_insert_pkg::PRBS_INIT
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic [31:0]        DAT_I,
  input  logic               WE_I,
  input  logic               STB_I,
  input  logic               CYC_I,
  output logic               ACK_O,
  output logic [31:0]        DAT_O,
  output logic               CYC_O,
  output logic               STB_O,
  output logic               WE_O,
  input  logic               ACK_I,
  input  logic [2*N_CAR-1:0] ALLOC_VEC,
  output logic               VEC_LD
);
  import pilot_insert_pkg::*;
  localparam int CW = N_CAR > 1 ? $clog2(N_CAR) : 1;
  state_t state;
  logic [CW-1:0] car_cnt;
  logic [2*N_CAR-1:0] alloc_reg;
  logic [1:0] c;
  logic [31:0] next_word;
  logic cyc_pp, wk, datin_val, halt, rise, last, is_data, adv, load, wrap;
  assign c         = alloc_reg[2*car_cnt +: 2];
  assign is_data   = c == ALLOC_DATA;
  assign datin_val = WE_I & STB_I & CYC_I;
  assign halt      = STB_O & ~ACK_I;
  assign rise      = CYC_I & ~cyc_pp;
  assign last      = car_cnt == CW'(N_CAR - 1);
  assign load      = (state == IDLE) & rise;
  // FLUSH never waits for input: data carriers go out as zero
  assign adv       = ~halt & (((state == RUN) & (~is_data | datin_val)) | (state == FLUSH));
  assign wrap      = adv & last;
  assign ACK_O     = datin_val & ~halt & (state == RUN) & is_data;
  assign WE_O      = CYC_O;
  assign next_word = c[ALLOC_PILOT] ? pilot_word(wk, PILOT_AMP) :
                     (is_data & (state == RUN)) ? DAT_I : 32'h0;
  pilot_prbs #(.INIT(PRBS_INIT)) u_prbs (
    .clk(CLK_I), .rst_n(RST_I), .load(load), .step(wrap), .wk(wk)
  );
  always_ff @(posedge CLK_I) begin
    cyc_pp <= RST_I ? CYC_I : 1'b1;
    if (!RST_I) begin
      state     <= IDLE;
      car_cnt   <= '0;
      alloc_reg <= '0;
      DAT_O     <= '0;
      STB_O     <= 1'b0;
      CYC_O     <= 1'b0;
      VEC_LD    <= 1'b0;
    end else begin
      VEC_LD <= load | wrap;
      if (load | wrap) alloc_reg <= ALLOC_VEC;
      if (load) begin
        car_cnt <= '0;
        CYC_O   <= 1'b1;
        state   <= RUN;
      end
      if (adv) begin
        DAT_O   <= next_word;
        STB_O   <= 1'b1;
        car_cnt <= last ? '0 : car_cnt + 1'b1;
      end else if (~halt & ((state == RUN) | (state == FLUSH))) STB_O <= 1'b0;
      if ((state == RUN) & ~CYC_I) state <= wrap ? DRAIN : FLUSH;
      if ((state == FLUSH) & wrap) state <= DRAIN;
      if ((state == DRAIN) & ~halt) begin
        STB_O <= 1'b0;
        CYC_O <= 1'b0;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_pilot_insert.sv
// tb_pilot_insert: directed self-checking bench for pilot_insert with a 4-carrier symbol
module tb_pilot_insert;
  logic clk, rst_n, we, stb, cyc, ack_i, ack_o, cyc_o, stb_o, we_o, vec_ld;
  logic [31:0] dat_i, dat_o;
  logic [7:0] alloc;
  logic [31:0] din_q[$];
  logic [31:0] out_q[$];
  logic feed_en;
  int ack_cnt, vld_cnt, n_chk, n_fail;
  localparam logic [31:0] D0 = 32'h1234_5678, D1 = 32'hDEAD_BEEF, D2 = 32'h0F0F_A5A5, D3 = 32'h8000_7FFF;
  localparam logic [31:0] PN = 32'h0000_E000, PP = 32'h0000_2000;
  pilot_insert #(.N_CAR(4)) dut (
    .CLK_I(clk), .RST_I(rst_n), .DAT_I(dat_i), .WE_I(we), .STB_I(stb), .CYC_I(cyc),
    .ACK_O(ack_o), .DAT_O(dat_o), .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o),
    .ACK_I(ack_i), .ALLOC_VEC(alloc), .VEC_LD(vec_ld)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (ack_o) begin
      ack_cnt++;
      if (din_q.size() != 0) void'(din_q.pop_front());
    end
    if (stb_o && ack_i) out_q.push_back(dat_o);
    if (vec_ld) vld_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic refresh();
    stb   = feed_en && din_q.size() != 0;
    dat_i = din_q.size() != 0 ? din_q[0] : 32'h0;
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      refresh();
    end
  endtask
  task automatic start(input logic [7:0] a);
    alloc   = a;
    ack_cnt = 0;
    vld_cnt = 0;
    out_q.delete();
    cyc     = 1'b1;
    refresh();
  endtask
  task automatic end_frame(input string tag);
    int n = 0;
    while (cyc_o && n < 30) begin
      step(1);
      n++;
    end
    chk({tag, "_idle"}, {31'h0, cyc_o}, 32'h0);
    feed_en = 1'b0;
    din_q.delete();
    refresh();
    step(1);
  endtask
  task automatic chk_outs(input string tag, input logic [31:0] e0, e1, e2, e3);
    logic [31:0] e[4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_cnt"}, {31'h0, out_q.size() >= 4}, 32'h1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_out%0d", tag, i), i < out_q.size() ? out_q[i] : 32'hBAD0_BAD0, e[i]);
  endtask
  initial begin
    n_chk = 0; n_fail = 0; ack_cnt = 0; vld_cnt = 0;
    rst_n = 1'b0; cyc = 1'b0; we = 1'b1; ack_i = 1'b1; alloc = 8'h0; feed_en = 1'b0;
    refresh();
    step(2);
    chk("rst_stb", {31'h0, stb_o}, 0);
    chk("rst_cyc", {31'h0, cyc_o}, 0);
    chk("rst_we", {31'h0, we_o}, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_vld", {31'h0, vec_ld}, 0);
    rst_n = 1'b1;
    step(1);
    // [data,pilot,null,data]
    din_q = '{D0, D1}; feed_en = 1'b1;
    start(8'h49);
    step(5);
    cyc = 1'b0;
    end_frame("t1");
    chk_outs("t1", D0, PN, 32'h0, D1);
    chk("t1_acks", ack_cnt, 2);
    // two all-pilot symbols: sign flips after the first PRBS step
    start(8'hAA);
    step(1);
    chk("t2_vld_start", {31'h0, vec_ld}, 1);
    step(7);
    cyc = 1'b0;
    end_frame("t2");
    chk("t2_n", out_q.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_out%0d", i), i < out_q.size() ? out_q[i] : 32'hBAD0_BAD0, i < 4 ? PN : PP);
    chk("t2_vld", vld_cnt, 3);
    chk("t2_acks", ack_cnt, 0);
    // downstream stall mid-symbol, alloc [data,data,pilot,null]
    din_q = '{D0, D1}; feed_en = 1'b1;
    start(8'h25);
    step(2);
    chk("t3_first", dat_o, D0);
    ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t3_stb_hold", {31'h0, stb_o}, 1);
      chk("t3_dat_hold", dat_o, D0);
      chk("t3_no_ack", {31'h0, ack_o}, 0);
    end
    ack_i = 1'b1;
    step(2);
    cyc = 1'b0;
    end_frame("t3");
    chk_outs("t3", D0, D1, PN, 32'h0);
    chk("t3_n", out_q.size(), 4);
    chk("t3_acks", ack_cnt, 2);
    // input starvation on carrier 1
    din_q = '{D0, D1}; feed_en = 1'b1;
    start(8'h25);
    step(2);
    feed_en = 1'b0;
    refresh();
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t4_bubble", {31'h0, stb_o}, 0);
    end
    feed_en = 1'b1;
    refresh();
    step(2);
    cyc = 1'b0;
    end_frame("t4");
    chk_outs("t4", D0, D1, PN, 32'h0);
    chk("t4_n", out_q.size(), 4);
    // CYC_I drops after carrier 1 of an all-data symbol
    din_q = '{D0, D1, D2, D3}; feed_en = 1'b1;
    start(8'h55);
    step(3);
    cyc = 1'b0;
    step(3);
    chk("t5_cyc_hold", {31'h0, cyc_o}, 1);
    step(1);
    chk("t5_cyc_fall", {31'h0, cyc_o}, 0);
    end_frame("t5");
    chk_outs("t5", D0, D1, 32'h0, 32'h0);
    chk("t5_acks", ack_cnt, 2);
    // reset after one symbol + one carrier, then restart from carrier 0 with a fresh PRBS
    start(8'h82);
    step(6);
    rst_n = 1'b0;
    step(1);
    chk("t6_stb", {31'h0, stb_o}, 0);
    chk("t6_cyc", {31'h0, cyc_o}, 0);
    chk("t6_we", {31'h0, we_o}, 0);
    chk("t6_dat", dat_o, 0);
    chk("t6_vld", {31'h0, vec_ld}, 0);
    chk("t6_ack", {31'h0, ack_o}, 0);
    rst_n = 1'b1;
    cyc = 1'b0;
    step(1);
    start(8'h82);
    step(4);
    cyc = 1'b0;
    end_frame("t6");
    chk_outs("t6", PN, 32'h0, 32'h0, PN);
    chk("t6_n", out_q.size(), 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
